// File: rtl/obi_fetch_prefetch_buffer.sv
// Sequential OBI instruction prefetcher with a small response FIFO.
// A branch flushes buffered words and discards responses still in flight.
module obi_fetch_prefetch_buffer #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 branch_i,
  input  logic [AddrWidth-1:0] branch_addr_i,
  output logic                 fetch_valid_o,
  input  logic                 fetch_ready_i,
  output logic [DataWidth-1:0] fetch_rdata_o,
  output logic [AddrWidth-1:0] fetch_addr_o,
  output logic                 fetch_err_o,
  output logic                 obi_req_o,
  output logic [AddrWidth-1:0] obi_addr_o,
  input  logic                 obi_gnt_i,
  input  logic                 obi_rvalid_i,
  input  logic [DataWidth-1:0] obi_rdata_i,
  input  logic                 obi_err_i,
  output logic                 busy_o
);
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam logic [AddrWidth-1:0] StepA = AddrWidth'(DataWidth / 8);
  localparam logic [AddrWidth-1:0] AlignMask = ~(StepA - AddrWidth'(1));
  localparam logic [CntW:0] DepthW = (CntW + 1)'(FifoDepth);
  localparam logic [CntW-1:0] DepthC = CntW'(FifoDepth);
  localparam logic [CntW-1:0] MaxOutC = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FifoDepth - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   next_addr_q, tgt_q, rsp_addr_q;
  logic [CntW-1:0]        out_q, disc_q, count_q;
  logic [PtrW-1:0]        wr_q, rd_q;
  logic [DataWidth-1:0]   data_mem [FifoDepth];
  logic [AddrWidth-1:0]   addr_mem [FifoDepth];
  logic [FifoDepth-1:0]   err_mem;

  logic [CntW:0]          inflight;
  logic [CntW-1:0]        out_nxt;
  logic [AddrWidth-1:0]   target;
  logic                   credit, req_gnt, drop, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign target   = branch_addr_i & AlignMask;
  assign inflight = {1'b0, out_q} + {1'b0, count_q};
  assign credit   = (inflight < DepthW) && (out_q < MaxOutC);
  // HOLD keeps the ungranted old request on the bus until its grant
  assign obi_req_o  = (state_q == HOLD) || ((state_q == RUN) && credit);
  assign obi_addr_o = next_addr_q;
  assign req_gnt    = obi_req_o & obi_gnt_i;
  assign drop       = obi_rvalid_i & (disc_q != '0);
  assign push       = obi_rvalid_i & (disc_q == '0) & ~branch_i;
  assign pop        = fetch_valid_o & fetch_ready_i;
  assign out_nxt    = out_q + CntW'(req_gnt) - CntW'(obi_rvalid_i);

  assign fetch_valid_o = (count_q != '0);
  assign fetch_rdata_o = data_mem[rd_q];
  assign fetch_addr_o  = addr_mem[rd_q];
  assign fetch_err_o   = err_mem[rd_q];
  assign busy_o        = (out_q != '0) || (disc_q != '0) || (state_q == HOLD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      next_addr_q <= '0;
      tgt_q       <= '0;
      rsp_addr_q  <= '0;
      out_q       <= '0;
      disc_q      <= '0;
      count_q     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      err_mem     <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else begin
      out_q <= out_nxt;
      if (req_gnt) next_addr_q <= next_addr_q + StepA;

      unique case (state_q)
        IDLE: if (branch_i) begin
          next_addr_q <= target;
          state_q     <= RUN;
        end
        RUN: if (branch_i) begin
          if (obi_req_o && !obi_gnt_i) begin
            tgt_q   <= target;
            state_q <= HOLD;
          end else begin
            next_addr_q <= target;
          end
        end
        HOLD: begin
          if (obi_gnt_i) begin
            next_addr_q <= branch_i ? target : tgt_q;
            state_q     <= RUN;
          end else if (branch_i) begin
            tgt_q <= target;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Everything still outstanding after this cycle belongs to the old stream
      if (branch_i)                           disc_q <= out_nxt;
      else if (state_q == HOLD && obi_gnt_i)  disc_q <= disc_q + CntW'(1) - CntW'(drop);
      else if (drop)                          disc_q <= disc_q - CntW'(1);

      if (branch_i)  rsp_addr_q <= target;
      else if (push) rsp_addr_q <= rsp_addr_q + StepA;

      if (branch_i) begin
        count_q <= '0;
        wr_q    <= '0;
        rd_q    <= '0;
      end else begin
        if (push) begin
          data_mem[wr_q] <= obi_rdata_i;
          addr_mem[wr_q] <= rsp_addr_q;
          err_mem[wr_q]  <= obi_err_i;
          wr_q           <= ptr_inc(wr_q);
        end
        if (pop) rd_q <= ptr_inc(rd_q);
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i) assert (!(push && count_q == DepthC));
  end
endmodule
